// File: rtl/onc_16_dmem_pkg.sv
// onc_16_dmem_pkg
// Shared definitions for the onc_16 data-memory stage.
//   `DATA_W        : core data/address word width
//   `DATA_UD       : value returned for unmapped or empty reads
//   `MMIO_*        : MMIO register offsets (dmem_addr[7:0])
// The package adds the STATUS bit layout and a helper that packs it.
// Optional feature macro used by the top: ONC_16_DMEM_TIMER_EN.

`ifndef ONC_16_DEF_DEFINED
`define ONC_16_DEF_DEFINED
`define DATA_W        16
`define DATA_UD       16'h0000
`define MMIO_OUT_DATA 8'h00
`define MMIO_STATUS   8'h01
`define MMIO_GPIO     8'h02
`define MMIO_TIMER    8'h03
`endif

package onc_16_dmem_pkg;

   localparam int STATUS_COUNT_W = 5;

   // STATUS layout: bit0 full, bit1 empty, bit2 overflow, bits[8:4] count.
   function automatic logic [`DATA_W-1:0] pack_status(
      input logic                      full,
      input logic                      empty,
      input logic                      overflow,
      input logic [STATUS_COUNT_W-1:0] count
   );
      return {7'b0, count, 1'b0, overflow, empty, full};
   endfunction

endpackage

// File: rtl/onc_16_fifo.sv
// onc_16_fifo
// Synchronous FIFO with registered count. A push while full is only taken
// when a pop happens on the same edge. The head word reads as zero when empty.
// Ports:
//   clock, n_rst : clock and synchronous active-low reset
//   push, din    : write request and data
//   pop          : read request (ignored when empty)
//   dout         : head entry (0 when empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH

import onc_16_dmem_pkg::*;

module onc_16_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clock,
   input  logic             n_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array is never reset; stale entries are hidden by the count.
   always_ff @(posedge clock) begin
      if (n_rst && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/onc_16_dmem.sv
// onc_16_dmem
// Data-memory stage for the onc_16 core: data RAM plus an MMIO window holding
// an output FIFO, its STATUS register, a GPIO register and an optional timer.
// Loads are combinational so the single-cycle core sees data the same cycle.
// Optional feature: define ONC_16_DMEM_TIMER_EN to build the 16-bit cycle
// timer at offset TIMER; otherwise that offset reads 0 and ignores writes.
// Ports:
//   clock, n_rst           : clock and synchronous active-low reset
//   dmem_addr/dout/we      : address, store data and store strobe from core
//   dmem_din               : load data to core
//   out_data/valid/ready   : FIFO head towards the external sink
//   gpio_out               : GPIO register value

import onc_16_dmem_pkg::*;

module onc_16_dmem #(
   parameter int                  RAM_AW     = 12,
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [`DATA_W-1:0]  MMIO_BASE  = 16'hFF00
) (
   input  logic               clock,
   input  logic               n_rst,
   input  logic [`DATA_W-1:0] dmem_addr,
   input  logic [`DATA_W-1:0] dmem_dout,
   input  logic               dmem_we,
   output logic [`DATA_W-1:0] dmem_din,
   output logic [`DATA_W-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [`DATA_W-1:0] gpio_out
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic [`DATA_W-1:0]        ram [0:(2**RAM_AW)-1];
   logic                      is_ram;
   logic                      is_mmio;
   logic [7:0]                offset;
   logic                      ram_we;
   logic                      mmio_we;
   logic                      push_req;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [FCW-1:0]            fifo_count;
   logic [STATUS_COUNT_W-1:0] status_count;
   logic                      overflow;
   logic [`DATA_W-1:0]        timer_val;

   // RAM wins if it ever overlaps the MMIO window; stores need n_rst high.
   assign is_ram       = ({16'b0, dmem_addr} < (32'd1 << RAM_AW));
   assign is_mmio      = (dmem_addr[15:8] == MMIO_BASE[15:8]) && !is_ram;
   assign offset       = dmem_addr[7:0];
   assign ram_we       = n_rst & dmem_we & is_ram;
   assign mmio_we      = n_rst & dmem_we & is_mmio;
   assign push_req     = mmio_we && (offset == `MMIO_OUT_DATA);
   assign pop          = out_valid & out_ready;
   assign out_valid    = ~fifo_empty;
   assign status_count = STATUS_COUNT_W'(fifo_count);

   onc_16_fifo #(
      .WIDTH (`DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .n_rst (n_rst),
      .push  (push_req),
      .din   (dmem_dout),
      .pop   (pop),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // RAM contents survive reset; a read in the write cycle still sees old data.
   always_ff @(posedge clock) begin
      if (ram_we) begin
         ram[dmem_addr[RAM_AW-1:0]] <= dmem_dout;
      end
   end

   // Overflow is sticky; a dropped push beats a STATUS write on the same edge.
   always_ff @(posedge clock) begin
      if (!n_rst) begin
         overflow <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else if (mmio_we && (offset == `MMIO_STATUS)) begin
         overflow <= 1'b0;
      end
   end

   // GPIO output register.
   always_ff @(posedge clock) begin
      if (!n_rst) begin
         gpio_out <= '0;
      end else if (mmio_we && (offset == `MMIO_GPIO)) begin
         gpio_out <= dmem_dout;
      end
   end

`ifdef ONC_16_DMEM_TIMER_EN
   // Free-running cycle counter; a store loads it and counting resumes from there.
   always_ff @(posedge clock) begin
      if (!n_rst) begin
         timer_val <= '0;
      end else if (mmio_we && (offset == `MMIO_TIMER)) begin
         timer_val <= dmem_dout;
      end else begin
         timer_val <= timer_val + 16'd1;
      end
   end
`else
   assign timer_val = '0;
`endif

   // Load mux: RAM, then MMIO registers, everything else reads as zero.
   always_comb begin
      dmem_din = `DATA_UD;
      if (is_ram) begin
         dmem_din = ram[dmem_addr[RAM_AW-1:0]];
      end else if (is_mmio) begin
         case (offset)
            `MMIO_OUT_DATA: dmem_din = out_data;
            `MMIO_STATUS:   dmem_din = pack_status(fifo_full, fifo_empty, overflow, status_count);
            `MMIO_GPIO:     dmem_din = gpio_out;
            `MMIO_TIMER:    dmem_din = timer_val;
            default:        dmem_din = `DATA_UD;
         endcase
      end
   end

endmodule
